// File: rtl/step_tick_pkg.sv
// Shared constants for the LED-rotator step tick generator.
package step_tick_pkg;

  localparam int unsigned NB_SEL     = 2;
  localparam int unsigned NB_CNT_DEF = 32;

  // Default periods in clk cycles; each halves the previous one.
  localparam int unsigned LIM0_DEF = 50000000;
  localparam int unsigned LIM1_DEF = 25000000;
  localparam int unsigned LIM2_DEF = 12500000;
  localparam int unsigned LIM3_DEF = 6250000;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/step_tick_gen_if.sv
// Switch inputs and LED/strobe outputs of the step tick generator.
interface step_tick_gen_if;
  import step_tick_pkg::*;

  logic              i_enable;
  logic [NB_SEL-1:0] i_sel;
  logic              o_valid;
  logic              o_blink;
  logic              o_run;

  modport master (output i_enable, output i_sel, input o_valid, input o_blink, input o_run);
  modport slave  (input i_enable, input i_sel, output o_valid, output o_blink, output o_run);

endinterface

// File: rtl/step_tick_gen_sync_2ff.sv
// One-bit two-flop synchronizer for asynchronous switch inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_tick_gen.sv
// Step strobe generator: selectable period, pause/resume, blink and run status.
module step_tick_gen
  import step_tick_pkg::*;
#(
  parameter int unsigned NB_CNT = NB_CNT_DEF,
  parameter int unsigned LIM0   = LIM0_DEF,
  parameter int unsigned LIM1   = LIM1_DEF,
  parameter int unsigned LIM2   = LIM2_DEF,
  parameter int unsigned LIM3   = LIM3_DEF
) (
  input  logic            clk,
  input  logic            i_rst_n,
  step_tick_gen_if.slave  bus
);

  logic              en_s;
  logic [NB_SEL-1:0] sel_s;
  logic [NB_SEL-1:0] sel_q;
  logic [NB_CNT-1:0] cnt;
  logic [NB_CNT-1:0] lim_m1;
  state_e            state;
  logic              valid_q;
  logic              blink_q;
  logic              run_q;

  sync_2ff u_sync_en (
    .clk   (clk),
    .rst_n (i_rst_n),
    .d     (bus.i_enable),
    .q     (en_s)
  );

  for (genvar g = 0; g < int'(NB_SEL); g++) begin : g_sync_sel
    sync_2ff u_sync_sel (
      .clk   (clk),
      .rst_n (i_rst_n),
      .d     (bus.i_sel[g]),
      .q     (sel_s[g])
    );
  end

  // Terminal count for the currently selected rate.
  always_comb begin
    lim_m1 = NB_CNT'(LIM0 - 1);
    case (sel_s)
      2'd0:    lim_m1 = NB_CNT'(LIM0 - 1);
      2'd1:    lim_m1 = NB_CNT'(LIM1 - 1);
      2'd2:    lim_m1 = NB_CNT'(LIM2 - 1);
      default: lim_m1 = NB_CNT'(LIM3 - 1);
    endcase
  end

  // o_run follows the next state so it is high exactly while in RUN.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      blink_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      sel_q <= sel_s;
      case (state)
        IDLE: begin
          cnt     <= '0;
          valid_q <= 1'b0;
          run_q   <= en_s;
          if (en_s) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!en_s) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            run_q   <= 1'b0;
          end else begin
            run_q <= 1'b1;
            // A rate change restarts the period and suppresses any pending pulse.
            if (sel_s != sel_q) begin
              cnt     <= '0;
              valid_q <= 1'b0;
            end else if (cnt == lim_m1) begin
              cnt     <= '0;
              valid_q <= 1'b1;
              blink_q <= ~blink_q;
            end else begin
              cnt     <= cnt + NB_CNT'(1);
              valid_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_blink = blink_q;
  assign bus.o_run   = run_q;

endmodule

// File: tb/tb_step_tick_gen.sv
// Bench for step_tick_gen: directed timeline with literal expectations plus randomized run against a model.
module tb_step_tick_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  step_tick_gen_if bus ();

  step_tick_gen #(
    .NB_CNT (8),
    .LIM0   (4),
    .LIM1   (6),
    .LIM2   (8),
    .LIM3   (10)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lim_of(input logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 6;
      2'd2:    return 8;
      default: return 10;
    endcase
  endfunction

  // Model: pulses fall every lim edges after the edge where counting started
  // from zero (run entry or rate restart); inputs are seen two edges late.
  int         n;
  int         ref_e;
  logic       h_en [4];
  logic [1:0] h_sel[4];
  logic       m_valid, m_blink, m_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      ref_e = 0;
      for (int i = 0; i < 4; i++) begin
        h_en[i]  = 1'b0;
        h_sel[i] = 2'd0;
      end
      m_valid = 1'b0;
      m_blink = 1'b0;
      m_run   = 1'b0;
    end else begin
      n++;
      for (int i = 3; i > 0; i--) begin
        h_en[i]  = h_en[i-1];
        h_sel[i] = h_sel[i-1];
      end
      h_en[0]  = bus.i_enable;
      h_sel[0] = bus.i_sel;
      m_valid  = 1'b0;
      if (h_en[2] && !h_en[3]) begin
        ref_e = n;
      end else if (h_en[2] && h_en[3]) begin
        if (h_sel[2] != h_sel[3]) begin
          ref_e = n;
        end else if ((n - ref_e) % lim_of(h_sel[2]) == 0) begin
          m_valid = 1'b1;
          m_blink = ~m_blink;
        end
      end
      m_run = h_en[2];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", int'(bus.o_valid), int'(m_valid));
      chk("model_blink", int'(bus.o_blink), int'(m_blink));
      chk("model_run",   int'(bus.o_run),   int'(m_run));
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, int'(bus.o_valid), 0);
    chk({name, "_blink"}, int'(bus.o_blink), 0);
    chk({name, "_run"},   int'(bus.o_run),   0);
  endtask

  initial begin
    int npulse;
    logic exp_v, exp_r;
    bus.i_enable = 1'b1;
    bus.i_sel    = 2'd0;

    // Reset held with enable high: everything stays cleared.
    repeat (4) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    #1 rst_n = 1'b1;
    @(posedge clk);  // E0

    // Directed timeline: sel 0, rate change at terminal count, pause, resume.
    npulse = 0;
    for (int k = 1; k <= 48; k++) begin
      if (k == 16) bus.i_sel = 2'd1;
      if (k == 32) bus.i_enable = 1'b0;
      if (k == 40) bus.i_enable = 1'b1;
      @(posedge clk);
      #1;
      exp_v = (k == 6 || k == 10 || k == 14 || k == 24 || k == 30 || k == 48);
      exp_r = (k >= 2 && k <= 33) || (k >= 42);
      if (exp_v) npulse++;
      chk($sformatf("dir_valid_E%0d", k), int'(bus.o_valid), int'(exp_v));
      chk($sformatf("dir_run_E%0d", k),   int'(bus.o_run),   int'(exp_r));
      if (exp_v || k == 40)
        chk($sformatf("dir_blink_E%0d", k), int'(bus.o_blink), npulse % 2);
    end

    // Async reset mid-run with cnt at 3.
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    chk_zero("async_rst_hold");
    #1 rst_n = 1'b1;
    @(posedge clk);  // E0 again, sel 1 -> lim 6
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("restart_valid_E%0d", k), int'(bus.o_valid), int'(k == 8));
      chk($sformatf("restart_run_E%0d", k),   int'(bus.o_run),   int'(k >= 2));
    end

    // Randomized switches and occasional resets, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 39) == 0) bus.i_enable = ~bus.i_enable;
      if ($urandom_range(0, 24) == 0) bus.i_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1 chk_zero("rand_rst");
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_tick_gen.md
Name: step_tick_gen

Overview:
- Upstream stage of the 4-position LED rotator. Generates the single-cycle step strobe that drives the rotator's i_valid input.
- Step period is selected from four rates by slide switches, and an enable switch pauses or resumes stepping.
- Switch inputs are asynchronous to clk and are synchronized inside this block.
- Also provides a blink toggle and a run-status output for the board LEDs.

Parameters:
- NB_CNT, 32, counter width in bits.
- LIM0, 50000000, period in clk cycles for i_sel=0.
- LIM1, 25000000, period for i_sel=1.
- LIM2, 12500000, period for i_sel=2.
- LIM3, 6250000, period for i_sel=3.
- Constraint: every LIMx must satisfy 2 <= LIMx <= 2**NB_CNT-1.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  async switch: 1 = run, 0 = pause.
- i_sel  in  2  async switches: rate select.
- o_valid  out  1  step strobe, one cycle high per period; connects to the rotator's i_valid.
- o_blink  out  1  toggles on every o_valid pulse.
- o_run  out  1  1 while the FSM is in RUN.

Behaviour:
- Reset (asynchronous, active-low): while i_rst_n=0, all outputs and internal state are cleared.
  - o_valid=0, o_blink=0, o_run=0, cnt=0, state=IDLE.
  - Synchronizer flops=0; sel_q=0.
  - Reset asserted mid-count clears everything immediately, with no pulse.
- Synchronization: i_enable and i_sel each pass through 2 flops, giving en_s and sel_s. sel_q is the registered copy of sel_s.
- Limit mux: lim = LIM[sel_s].
- FSM, two states, registered:
  - IDLE: cnt<=0, o_valid<=0, o_run<=0. When en_s=1, go to RUN with cnt<=0.
  - RUN: o_run<=1. When en_s=0, go to IDLE, cnt<=0, o_valid<=0, and o_blink holds its value.
- Counting in RUN, with this priority order:
  1. Rate change: if sel_s!=sel_q, cnt<=0 and o_valid<=0. This is a restart; no pulse even if cnt==lim-1.
  2. Terminal count: else if cnt==lim-1, cnt<=0, o_valid<=1, o_blink<=~o_blink.
  3. Otherwise: cnt<=cnt+1, o_valid<=0.
- Period: consecutive o_valid rising edges are exactly lim cycles apart. o_valid is never high on two consecutive cycles.
- Start latency: let E0 be the first edge sampling i_enable=1.
  - en_s=1 after E1; state=RUN after E2.
  - First o_valid=1 is registered at edge E(lim+2).
- Disable mid-count: the partial count is discarded. The next run restarts from 0 with the full start latency.
- Arithmetic: cnt is unsigned NB_CNT bits and never exceeds lim-1, so there is no overflow or wrap other than the terminal reset.
- Outputs are driven only from flops; there are no combinational paths from input to output.

Decomposition:
- Package step_tick_pkg contains:
  - State encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default limit constants.
  - NB_SEL=2.
- One sub-module: sync_2ff, a 1-bit 2-flop synchronizer with the same clock and reset. It is instantiated three times (enable plus 2 select bits).
- Counter and FSM stay in the top module.

Test Plan:
All scenarios use overrides LIM0=4, LIM1=6, LIM2=8, LIM3=10 and NB_CNT=8.
- Reset: hold i_rst_n=0 with i_enable=1 -> o_valid=0, o_blink=0, o_run=0 throughout. Release reset, with E0 = first edge after release -> o_run=1 after E2.
- Start and period with sel=0: raise i_enable before E0 -> o_valid pulses registered at E6, E10, E14, each exactly 1 cycle wide. o_blink reads 1, 0, 1 after each pulse.
- Rate change: running at sel=0, switch i_sel to 2 -> no pulse at the restart edge. Next pulse comes 8 cycles after the restart, then the period is 8.
- Rate change at terminal count: sel_s changes on the same edge where cnt==3 -> no pulse at that edge; cnt restarts at 0.
- Pause and resume: drop i_enable mid-count at cnt=2 -> o_run=0 two cycles later, no pulses, o_blink holds. Re-enable -> first pulse lim+2 edges after re-enable, counted from 0.
- Async reset mid-run: assert i_rst_n low between edges with cnt=3 -> all outputs 0 immediately with no pulse. After release, the start sequence repeats.
